muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: radix-2 shift-add
// multiply, restoring divide, one bit per cycle, stall-release via isDone.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  isMulE,
  input  logic                  killE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] srcAE,
  input  logic [DATA_WIDTH-1:0] srcBE,
  output logic                  isDone,
  output logic [DATA_WIDTH-1:0] mulResultE
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic is_mul;
    logic hi;
    logic rem;
    logic neg;
  } op_t;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  op_t            op;
  logic [W-1:0]   bmag;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   remr;

  // operand decode in IDLE
  logic           a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [W-1:0]   a_mag, b_mag, spec_res;
  op_t            op_in;

  always_comb begin
    a_sgn = (funct3E == 3'b001) || (funct3E == 3'b010) ||
            (funct3E == 3'b100) || (funct3E == 3'b110);
    b_sgn = (funct3E == 3'b001) || (funct3E == 3'b100) || (funct3E == 3'b110);
    a_neg = a_sgn & srcAE[W-1];
    b_neg = b_sgn & srcBE[W-1];
    a_mag = a_neg ? -srcAE : srcAE;
    b_mag = b_neg ? -srcBE : srcBE;
    div0  = funct3E[2] && (srcBE == '0);
    ovf   = funct3E[2] && !funct3E[0] && (srcAE == SMIN) && (srcBE == '1);
    if (funct3E[1]) spec_res = div0 ? srcAE : '0;
    else            spec_res = div0 ? '1 : SMIN;
    op_in.is_mul = ~funct3E[2];
    op_in.hi     = (funct3E[1:0] != 2'b00);
    op_in.rem    = funct3E[1];
    // remainder follows the dividend sign, everything else the product/quotient sign
    op_in.neg    = (funct3E[2] & funct3E[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // one iteration of both datapaths; only the one matching op is consumed
  logic [W:0]     msum, r_sh, r_df;
  logic [2*W-1:0] prod_nx, prod_fin;
  logic [W-1:0]   quot_nx, rem_nx, quot_fin, rem_fin, res_fin;

  always_comb begin
    msum     = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? bmag : {W{1'b0}})};
    prod_nx  = {msum, prod[W-1:1]};
    r_sh     = {remr, quot[W-1]};
    r_df     = r_sh - {1'b0, bmag};
    quot_nx  = {quot[W-2:0], ~r_df[W]};
    rem_nx   = r_df[W] ? r_sh[W-1:0] : r_df[W-1:0];
    // full-width negate so high-half results of signed multiplies are correct
    prod_fin = op.neg ? -prod_nx : prod_nx;
    quot_fin = op.neg ? -quot_nx : quot_nx;
    rem_fin  = op.neg ? -rem_nx  : rem_nx;
    if (op.is_mul) res_fin = op.hi ? prod_fin[2*W-1:W] : prod_fin[W-1:0];
    else           res_fin = op.rem ? rem_fin : quot_fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      bmag       <= '0;
      prod       <= '0;
      quot       <= '0;
      remr       <= '0;
      mulResultE <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isMulE && !killE) begin
            if (div0 || ovf) begin
              state      <= DONE;
              mulResultE <= spec_res;
            end else begin
              state <= BUSY;
              cnt   <= '0;
              op    <= op_in;
              bmag  <= b_mag;
              prod  <= {{W{1'b0}}, a_mag};
              quot  <= a_mag;
              remr  <= '0;
            end
          end
        end
        BUSY: begin
          if (killE) begin
            state <= IDLE;
          end else begin
            prod <= prod_nx;
            quot <= quot_nx;
            remr <= rem_nx;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(W-1)) begin
              state      <= DONE;
              mulResultE <= res_fin;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign isDone = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result/latency,
// a negedge monitor pops and compares on every isDone.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         isMulE = 1'b0;
  logic         killE = 1'b0;
  logic [2:0]   funct3E = 3'b000;
  logic [W-1:0] srcAE = '0;
  logic [W-1:0] srcBE = '0;
  logic         isDone;
  logic [W-1:0] mulResultE;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .isMulE(isMulE), .killE(killE),
    .funct3E(funct3E), .srcAE(srcAE), .srcBE(srcBE),
    .isDone(isDone), .mulResultE(mulResultE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           start;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   pass_n = 0;
  int   total_n = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && isDone) begin
      if (sb.size() == 0) begin
        total_n++;
        $display("FAIL spurious_done: got isDone=1 at cycle %0d want no pending op", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, longint'(mulResultE), longint'(e.res));
        chk({e.name, "_lat"}, longint'(cyc - e.start), longint'(e.lat));
      end
    end
  end

  task automatic wait_done(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (isDone) return;
    end
    total_n++;
    $display("FAIL %s_timeout: got no isDone want isDone within 100 cycles", nm);
  endtask

  // called at a negedge with the unit idle; returns at a negedge with the unit idle
  task automatic run(input string nm, input logic [2:0] f3, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                     input bit hold);
    funct3E = f3; srcAE = a; srcBE = b; isMulE = 1'b1; killE = 1'b0;
    sb.push_back('{exp, lat, cyc, nm});
    wait_done(nm);
    if (!hold) isMulE = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_only(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    funct3E = f3; srcAE = a; srcBE = b; isMulE = 1'b1; killE = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_isDone", longint'(isDone), 0);
    chk("reset_result", longint'(mulResultE), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("mul_7xm3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
    run("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,        33, 0);
    run("div_7_m2",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
    run("rem_7_m2",   3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 0);
    run("divu_5_0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run("remu_5_0",   3'b111, 32'd5,        32'd0,        32'd5,        1,  0);
    run("div_m5_0",   3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  0);
    run("rem_m5_0",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  0);
    run("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);

    // back-to-back with isMulE held through DONE
    run("b2b_3x4",    3'b000, 32'd3, 32'd4, 32'd12, 33, 1);
    run("b2b_5x6",    3'b000, 32'd5, 32'd6, 32'd30, 33, 0);

    // kill mid-BUSY: result holds, no done
    start_only(3'b000, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    killE = 1'b1; isMulE = 1'b0;
    @(negedge clk);
    killE = 1'b0;
    chk("kill_hold_result", longint'(mulResultE), 30);
    repeat (40) @(negedge clk);
    chk("kill_hold_result_late", longint'(mulResultE), 30);

    // kill wins over isMulE in IDLE
    start_only(3'b101, 32'd5, 32'd0);
    killE = 1'b1;
    @(negedge clk);
    isMulE = 1'b0; killE = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_kill_result", longint'(mulResultE), 30);
    run("after_kill", 3'b011, 32'h00010000, 32'h00010000, 32'd1, 33, 0);

    // reset mid-BUSY
    start_only(3'b000, 32'd11, 32'd11);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_isDone", longint'(isDone), 0);
    chk("rst_mid_result", longint'(mulResultE), 0);
    isMulE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_release_result", longint'(mulResultE), 0);
    run("after_rst", 3'b000, 32'd11, 32'd11, 32'd121, 33, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
